uart_rx_fifo: RTL and testbench

Receive front end of the UART loopback path. Deserializes 8N1 frames from the raw `UART_RX` pin into bytes and buffers them in a small first-word-fall-through FIFO. The FIFO has a valid/ready output that the transmit stage drains. It runs in the `CLK` domain produced by the clock wizard and is instantiated directly inside the loopback sub-block.

---
 rtl/uart_rx_fifo.sv | 91 +++++++++
 tb/tb_uart_rx_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO
module uart_rx_fifo #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          UART_RX,
  output logic [7:0]                    DOUT,
  output logic                          VALID,
  input  logic                          READY,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT,
  output logic                          FRAME_ERR,
  output logic                          OVERRUN
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state, state_n;
  logic rx_m, rx_s, hi;
  logic [1:0] live;
  logic [CW-1:0] cnt;
  logic [2:0] bit_i;
  logic [7:0] sh;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic tick, fall, push, ferr, pop, full, wr;
  // hi only counts once rx_s carries real pin data, so a line low out of reset is no start
  always_ff @(posedge CLK)
    if (!RST_N) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      live <= '0;
      hi   <= 1'b0;
    end else begin
      rx_m <= UART_RX;
      rx_s <= rx_m;
      live <= {live[0], 1'b1};
      hi   <= live[1] & rx_s;
    end
  assign tick = cnt == '0;
  assign fall = hi & ~rx_s;
  always_ff @(posedge CLK)
    if (!RST_N) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (fall) state_n = START;
      START:     if (tick) state_n = rx_s ? IDLE : DATA;
      DATA:      if (tick && bit_i == 3'd7) state_n = STOP;
      STOP:      if (tick) state_n = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_comb begin
    push = state == STOP && tick && rx_s;
    ferr = state == STOP && tick && !rx_s;
  end
  always_ff @(posedge CLK)
    if (!RST_N) begin
      cnt       <= '0;
      bit_i     <= '0;
      sh        <= '0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      cnt       <= state == IDLE ? CW'(CLK_PER_BIT / 2 - 1) : tick ? CW'(CLK_PER_BIT - 1) : cnt - CW'(1);
      bit_i     <= state != DATA ? 3'd0 : tick ? bit_i + 3'd1 : bit_i;
      sh        <= state == DATA && tick ? {rx_s, sh[7:1]} : sh;
      FRAME_ERR <= ferr;
      OVERRUN   <= push & full & ~pop;
    end
  assign COUNT = wp - rp;
  assign VALID = wp != rp;
  assign full  = COUNT == (AW+1)'(FIFO_DEPTH);
  assign pop   = VALID & READY;
  assign wr    = push & (~full | pop);
  assign DOUT  = VALID ? mem[rp[AW-1:0]] : 8'h00;
  always_ff @(posedge CLK)
    if (!RST_N) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(wr);
      rp <= rp + (AW+1)'(pop);
    end
  always_ff @(posedge CLK)
    if (wr) mem[wp[AW-1:0]] <= sh;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo at 16 clocks/bit, depth 4
module tb_uart_rx_fifo;
  logic CLK, RST_N, UART_RX, READY, VALID, FRAME_ERR, OVERRUN;
  logic [7:0] DOUT;
  logic [2:0] COUNT;
  logic [7:0] exp_q[$];
  int tests = 0, fails = 0, ferr_cnt = 0, ovr_cnt = 0;

  uart_rx_fifo #(.CLK_PER_BIT(16), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .UART_RX(UART_RX), .DOUT(DOUT), .VALID(VALID),
    .READY(READY), .COUNT(COUNT), .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N && VALID && READY) begin
      if (exp_q.size() == 0) chk("unexpected_pop", int'(DOUT), -1);
      else chk("sb_dout", int'(DOUT), int'(exp_q.pop_front()));
    end
    if (RST_N && (FRAME_ERR || OVERRUN)) chk("flag_excl", int'(FRAME_ERR && OVERRUN), 0);
    if (RST_N && FRAME_ERR) ferr_cnt++;
    if (RST_N && OVERRUN) ovr_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    UART_RX = 1'b0;
    cyc(16);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      cyc(16);
    end
    UART_RX = stop;
    cyc(16);
  endtask

  task automatic drain();
    READY = 1'b1;
    for (int i = 0; i < 20 && VALID; i++) cyc(1);
    READY = 1'b0;
    chk("drain_valid", int'(VALID), 0);
    chk("drain_sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b2b [3];
    logic [7:0] strm [10];
    int f0, o0;
    b2b  = '{8'h00, 8'hFF, 8'h55};
    strm = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'hA5, 8'h0F, 8'hF0, 8'h96, 8'h69};
    RST_N = 1'b0; UART_RX = 1'b0; READY = 1'b0;
    // 1: reset with line low, no start until the line goes high
    cyc(3);
    chk("rst_valid", int'(VALID), 0);
    chk("rst_count", int'(COUNT), 0);
    chk("rst_dout", int'(DOUT), 0);
    chk("rst_flags", int'({FRAME_ERR, OVERRUN}), 0);
    cyc(2);
    RST_N = 1'b1;
    cyc(40);
    chk("low_valid", int'(VALID), 0);
    chk("low_count", int'(COUNT), 0);
    chk("low_ferr", ferr_cnt, 0);
    UART_RX = 1'b1;
    cyc(32);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    chk("a5_dout", int'(DOUT), 8'hA5);
    chk("a5_valid", int'(VALID), 1);
    chk("a5_count", int'(COUNT), 1);
    drain();
    // 2: back-to-back frames
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(b2b[i]);
      send_frame(b2b[i], 1'b1);
      chk("b2b_count", int'(COUNT), i + 1);
    end
    READY = 1'b1;
    cyc(3);
    READY = 1'b0;
    chk("b2b_valid_fall", int'(VALID), 0);
    chk("b2b_sb_empty", exp_q.size(), 0);
    chk("b2b_ferr", ferr_cnt, 0);
    // 3: glitch rejection
    UART_RX = 1'b0;
    cyc(4);
    UART_RX = 1'b1;
    cyc(40);
    chk("glitch_count", int'(COUNT), 0);
    chk("glitch_ferr", ferr_cnt, 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    chk("post_glitch_count", int'(COUNT), 1);
    drain();
    // 4: framing error followed by a long break
    send_frame(8'h3C, 1'b0);
    cyc(640);
    chk("ferr_once", ferr_cnt, 1);
    chk("ferr_no_store", int'(COUNT), 0);
    UART_RX = 1'b1;
    cyc(16);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    chk("break_count", int'(COUNT), 1);
    chk("break_dout", int'(DOUT), 8'h81);
    chk("break_ferr", ferr_cnt, 1);
    drain();
    // 5: overrun on the fifth frame
    o0 = ovr_cnt;
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    chk("ovr_count", int'(COUNT), 4);
    chk("ovr_pulse", ovr_cnt - o0, 1);
    chk("ovr_head", int'(DOUT), 8'h01);
    drain();
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    o0 = ovr_cnt;
    fork
      send_frame(8'h05, 1'b1);
      begin
        cyc(154);
        READY = 1'b1;
        cyc(1);
        READY = 1'b0;
      end
    join
    chk("pop_push_no_ovr", ovr_cnt - o0, 0);
    chk("pop_push_count", int'(COUNT), 4);
    chk("pop_push_head", int'(DOUT), 8'h02);
    drain();
    // 6: reset mid-frame flushes the FIFO, then stream across pointer wrap
    f0 = ferr_cnt;
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    chk("pre_rst_count", int'(COUNT), 1);
    fork
      send_frame(8'hE5, 1'b1);
      begin
        cyc(88);
        RST_N = 1'b0;
        cyc(3);
        RST_N = 1'b1;
      end
    join
    exp_q.delete();
    cyc(32);
    chk("midrst_count", int'(COUNT), 0);
    chk("midrst_valid", int'(VALID), 0);
    chk("midrst_ferr", ferr_cnt - f0, 0);
    READY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(strm[i]);
      send_frame(strm[i], 1'b1);
    end
    cyc(4);
    READY = 1'b0;
    chk("wrap_sb_empty", exp_q.size(), 0);
    chk("wrap_count", int'(COUNT), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
